pulse_capture_sched: RTL and testbench

Sequences a bank of NUM_CH pulse-capture channels that share one tristate result bus. Arms the selected channels with a common trigger and watches their interrupt flags. Grants the shared bus round-robin, one channel at a time, and drives that channel's output enable, then its interrupt clear. Streams each width result to the host over a valid/ready interface, with optional one-shot or continuous re-arm.

---
 rtl/pulse_capture_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 23 ++
 rtl/pulse_capture_sched.sv | 185 ++++++++++++++++++
 tb/tb_pulse_capture_sched.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_capture_pkg.sv
// Shared types and helpers for the pulse-capture scheduler.
package pulse_capture_pkg;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_BUS_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT_W = 24;
  localparam int unsigned MAX_CH        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_READ,
    S_CLEAR,
    S_OUT
  } sched_state_t;

  function automatic logic [MAX_CH-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[IW'((32'(ptr) + i) % N)]) begin
        valid = 1'b1;
        grant = IW'((32'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/pulse_capture_sched.sv
// Round-robin scheduler for NUM_CH pulse-capture channels sharing one result bus.
// Optional capture-window timeout enabled by defining PULSE_CAPTURE_SCHED_TIMEOUT_EN.
module pulse_capture_sched
  import pulse_capture_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      continuous,
  input  logic [TIMEOUT_W-1:0]      timeout_val,
  output logic [NUM_CH-1:0]         cap_trig,
  input  logic [NUM_CH-1:0]         cap_int,
  output logic [NUM_CH-1:0]         cap_int_clr,
  output logic [NUM_CH-1:0]         cap_oe,
  input  logic [BUS_WIDTH-1:0]      cap_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [BUS_WIDTH-1:0]      res_data,
  output logic                      res_timeout,
  output logic                      busy,
  output logic                      round_done
);

  localparam int unsigned IW = $clog2(NUM_CH);

  sched_state_t      state;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] req;
  logic              cont_q;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     granted;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;

  // Only channels still owed a result in this round may win the bus.
  assign req = pending & cap_int;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_idx),
    .valid (arb_valid)
  );

`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tval_q;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [IW-1:0]        low_idx;
  logic                 low_seen;
  logic                 to_hit;

  always_comb begin
    low_idx  = '0;
    low_seen = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pending[i] && !low_seen) begin
        low_idx  = IW'(i);
        low_seen = 1'b1;
      end
    end
  end

  // tcnt saturates, so once expired every remaining channel times out in turn.
  assign to_hit = (tval_q != '0) && (tcnt >= tval_q) && (pending != '0);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_val;
  assign res_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      pending     <= '0;
      cont_q      <= 1'b0;
      rr_ptr      <= '0;
      granted     <= '0;
      cap_trig    <= '0;
      cap_int_clr <= '0;
      cap_oe      <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      busy        <= 1'b0;
      round_done  <= 1'b0;
`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
      tval_q      <= '0;
      tcnt        <= '0;
      res_timeout <= 1'b0;
`endif
    end else begin
      cap_trig    <= '0;
      cap_int_clr <= '0;
      cap_oe      <= '0;
      round_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (ch_mask != '0)) begin
            mask_q   <= ch_mask;
            cont_q   <= continuous;
            pending  <= ch_mask;
            cap_trig <= ch_mask;
            busy     <= 1'b1;
`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
            tval_q   <= timeout_val;
`endif
            state    <= S_ARM;
          end
        end
        S_ARM: begin
`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
          tcnt  <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (arb_valid) begin
            granted <= arb_idx;
            cap_oe  <= NUM_CH'(onehot(3'(arb_idx)));
            state   <= S_READ;
          end
`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            res_ch           <= low_idx;
            res_data         <= '0;
            res_timeout      <= 1'b1;
            res_valid        <= 1'b1;
            pending[low_idx] <= 1'b0;
            state            <= S_OUT;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_READ: begin
          res_data    <= cap_data;
          res_ch      <= granted;
`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
          res_timeout <= 1'b0;
`endif
          cap_int_clr <= NUM_CH'(onehot(3'(granted)));
          state       <= S_CLEAR;
        end
        S_CLEAR: begin
          pending   <= pending & ~NUM_CH'(onehot(3'(granted)));
          rr_ptr    <= (granted == IW'(NUM_CH - 1)) ? '0 : granted + 1'b1;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pending != '0) begin
              state <= S_WAIT;
            end else begin
              round_done <= 1'b1;
              if (cont_q && !stop) begin
                pending  <= mask_q;
                cap_trig <= mask_q;
                state    <= S_ARM;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_capture_sched.sv
// Self-checking bench for pulse_capture_sched: behavioural model plus directed literal checks.
module tb_pulse_capture_sched;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int TW = 24;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, continuous;
  logic [N-1:0]  ch_mask;
  logic [TW-1:0] timeout_val;
  logic [N-1:0]  cap_trig, cap_int, cap_int_clr, cap_oe;
  logic [BW-1:0] cap_data;
  logic          res_valid, res_ready, res_timeout, busy, round_done;
  logic [IW-1:0] res_ch;
  logic [BW-1:0] res_data;

  always #5 clk = ~clk;

  pulse_capture_sched #(
    .NUM_CH    (N),
    .BUS_WIDTH (BW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .ch_mask     (ch_mask),
    .continuous  (continuous),
    .timeout_val (timeout_val),
    .cap_trig    (cap_trig),
    .cap_int     (cap_int),
    .cap_int_clr (cap_int_clr),
    .cap_oe      (cap_oe),
    .cap_data    (cap_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ch      (res_ch),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .busy        (busy),
    .round_done  (round_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- channel and host emulation ----------------
  logic [N-1:0]  chan_int = '0;
  logic [N-1:0]  spur_int;
  logic [BW-1:0] chan_data [N];
  int            chan_cnt  [N];
  int            dir_delay [N];
  logic [BW-1:0] dir_data  [N];
  bit            rand_mode;
  int            ready_mode;
  int            trig_cnt = 0, done_cnt = 0, clr0_cnt = 0, clr3_cnt = 0;

  typedef struct packed {
    logic [IW-1:0] ch;
    logic [BW-1:0] data;
    logic          to;
  } res_t;
  res_t log_q[$];

  assign cap_int = chan_int | spur_int;

  always_comb begin
    cap_data = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++)
      if (cap_oe[i]) cap_data = chan_data[i];
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      chan_data[i] = '0;
      chan_cnt[i]  = 0;
    end
    res_ready = 1'b0;
  end

  // ---------------- behavioural model ----------------
  logic [N-1:0]  e_trig, e_oe, e_clr;
  logic          e_valid, e_busy, e_done, e_to;
  logic [IW-1:0] e_ch;
  logic [BW-1:0] e_data;
  logic [N-1:0]  m_mask, m_pending;
  logic          m_cont, m_wait;
  int            m_ptr, m_grant, m_tval;
  longint        m_wcnt;

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic int lowest(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[k]) return k;
    return 0;
  endfunction

  function automatic logic [N-1:0] oh_n(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_trig <= '0; e_oe <= '0; e_clr <= '0;
      e_valid <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0; e_to <= 1'b0;
      e_ch <= '0; e_data <= '0;
      m_mask <= '0; m_pending <= '0; m_cont <= 1'b0; m_wait <= 1'b0;
      m_ptr <= 0; m_grant <= 0; m_tval <= 0; m_wcnt <= 0;
    end else begin
      e_trig <= '0; e_oe <= '0; e_clr <= '0; e_done <= 1'b0;
      if (!e_busy) begin
        if (start && ch_mask != '0) begin
          m_mask <= ch_mask; m_cont <= continuous; m_tval <= int'(timeout_val);
          m_pending <= ch_mask; e_trig <= ch_mask; e_busy <= 1'b1;
        end
      end else if (e_trig != '0) begin
        m_wait <= 1'b1;
        m_wcnt <= 0;
      end else if (e_oe != '0) begin
        e_data <= chan_data[m_grant];
        e_ch   <= IW'(m_grant);
        e_to   <= 1'b0;
        e_clr  <= e_oe;
      end else if (e_clr != '0) begin
        m_pending <= m_pending & ~e_clr;
        m_ptr     <= (m_grant + 1) % N;
        e_valid   <= 1'b1;
      end else if (e_valid) begin
        if (res_ready) begin
          e_valid <= 1'b0;
          if (m_pending != '0) m_wait <= 1'b1;
          else begin
            e_done <= 1'b1;
            if (m_cont && !stop) begin
              m_pending <= m_mask;
              e_trig    <= m_mask;
            end else e_busy <= 1'b0;
          end
        end
      end else if (m_wait) begin
        if ((m_pending & cap_int) != '0) begin
          m_grant <= rr_first(m_pending & cap_int, m_ptr);
          e_oe    <= oh_n(rr_first(m_pending & cap_int, m_ptr));
          m_wait  <= 1'b0;
        end
`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
        else if (m_tval != 0 && m_wcnt >= m_tval) begin
          e_valid <= 1'b1;
          e_ch    <= IW'(lowest(m_pending));
          e_data  <= '0;
          e_to    <= 1'b1;
          m_pending[lowest(m_pending)] <= 1'b0;
          m_wait  <= 1'b0;
        end else if (m_wcnt < (longint'(1) << TW) - 1) begin
          m_wcnt <= m_wcnt + 1;
        end
`endif
      end
    end
  end

  // ---------------- compare + emulation (negedge) ----------------
  always @(negedge clk) begin
    chk("cap_trig", cap_trig, e_trig);
    chk("cap_oe", cap_oe, e_oe);
    chk("cap_int_clr", cap_int_clr, e_clr);
    chk("res_valid", res_valid, e_valid);
    chk("busy", busy, e_busy);
    chk("round_done", round_done, e_done);
    chk("strobe_excl", ((cap_trig != '0) + (cap_oe != '0) + (cap_int_clr != '0)) <= 1, 1);
    chk("oe_onehot0", $onehot0(cap_oe), 1);
    if (e_valid) begin
      chk("res_ch", res_ch, e_ch);
      chk("res_data", res_data, e_data);
      chk("res_timeout", res_timeout, e_to);
    end

    if (cap_trig != '0) trig_cnt++;
    if (round_done) done_cnt++;
    if (cap_int_clr[0]) clr0_cnt++;
    if (cap_int_clr[3]) clr3_cnt++;

    if (rst) begin
      chan_int = '0;
      for (int i = 0; i < N; i++) chan_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cap_trig[i]) begin
          chan_int[i]  = 1'b0;
          chan_data[i] = rand_mode ? $urandom : dir_data[i];
          chan_cnt[i]  = rand_mode ? int'($urandom_range(1, 25)) : dir_delay[i];
        end else if (chan_cnt[i] > 0) begin
          chan_cnt[i]--;
          if (chan_cnt[i] == 0) chan_int[i] = 1'b1;
        end
        if (cap_int_clr[i]) chan_int[i] = 1'b0;
      end
    end

    case (ready_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase

    if (!rst && res_valid && res_ready) log_q.push_back('{res_ch, res_data, res_timeout});
  end

  // ---------------- directed + random sequences ----------------
  task automatic do_start(input logic [N-1:0] m, input logic c, input logic [TW-1:0] t);
    @(negedge clk);
    ch_mask = m; continuous = c; timeout_val = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (log_q.size() >= target) return;
    end
    bound_expired(name);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    bound_expired(name);
  endtask

  task automatic set_dir(input int ch, input int dly, input logic [BW-1:0] d);
    dir_delay[ch] = dly;
    dir_data[ch]  = d;
  endtask

  initial begin
    int b, t0, d0, c0, c3;
    logic [N-1:0] m;
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    ch_mask = '0; timeout_val = '0; spur_int = '0;
    rand_mode = 1'b0; ready_mode = 0;
    for (int i = 0; i < N; i++) set_dir(i, -1, '0);
    repeat (3) @(negedge clk);
    chk("reset_valid", res_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_oe", cap_oe, 0);
    chk("reset_trig", cap_trig, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All four flags together from rr_ptr=0: served 0,1,2,3.
    for (int i = 0; i < N; i++) set_dir(i, 4, BW'(32'hA0 + i));
    b = log_q.size();
    do_start(4'b1111, 1'b0, '0);
    wait_results(b + 4, 200, "t2_results");
    wait_idle(50, "t2_idle");
    for (int i = 0; i < 4; i++) begin
      if (log_q.size() > b + i) begin
        chk("t2_order_ch", log_q[b + i].ch, i);
        chk("t2_order_data", log_q[b + i].data, 32'hA0 + i);
      end
    end

    // Mask 0101: ch2 first then ch0; ch3 raises a flag it does not own.
    for (int i = 0; i < N; i++) set_dir(i, -1, '0);
    set_dir(2, 5, 32'h64);
    set_dir(0, 20, 32'h10);
    b = log_q.size(); d0 = done_cnt; c3 = clr3_cnt;
    do_start(4'b0101, 1'b0, '0);
    spur_int[3] = 1'b1;
    wait_results(b + 2, 200, "t1_results");
    wait_idle(50, "t1_idle");
    chk("t1_count", log_q.size() - b, 2);
    if (log_q.size() >= b + 2) begin
      chk("t1_first_ch", log_q[b].ch, 2);
      chk("t1_first_data", log_q[b].data, 32'h64);
      chk("t1_second_ch", log_q[b + 1].ch, 0);
      chk("t1_second_data", log_q[b + 1].data, 32'h10);
    end
    chk("t1_round_done", done_cnt - d0, 1);
    chk("t1_spur_not_cleared", clr3_cnt - c3, 0);
    spur_int = '0;

    // Host stalls in OUT: result held stable, bus quiet.
    set_dir(0, -1, '0); set_dir(2, -1, '0);
    set_dir(1, 3, 32'h3C3C);
    ready_mode = 2;
    do_start(4'b0010, 1'b0, '0);
    begin
      int k;
      for (k = 0; k < 100 && !res_valid; k++) @(negedge clk);
      if (!res_valid) bound_expired("t3_valid");
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", res_valid, 1);
      chk("t3_hold_ch", res_ch, 1);
      chk("t3_hold_data", res_data, 32'h3C3C);
      chk("t3_quiet_oe", cap_oe, 0);
      chk("t3_quiet_clr", cap_int_clr, 0);
    end
    ready_mode = 0;
    wait_idle(50, "t3_idle");

    // Continuous re-arm on ch0 until stop.
    rand_mode = 1'b1; ready_mode = 1;
    b = log_q.size(); t0 = trig_cnt; d0 = done_cnt;
    do_start(4'b0001, 1'b1, '0);
    wait_results(b + 3, 500, "t4_results");
    stop = 1'b1;
    wait_idle(500, "t4_idle");
    stop = 1'b0;
    chk("t4_trig_per_result", trig_cnt - t0, log_q.size() - b);
    chk("t4_done_per_result", done_cnt - d0, log_q.size() - b);
    chk("t4_busy_low", busy, 0);
    for (int i = b; i < log_q.size(); i++) chk("t4_ch0", log_q[i].ch, 0);

    // Asynchronous reset while the bus is driven.
    rand_mode = 1'b0; ready_mode = 0;
    set_dir(1, -1, '0);
    set_dir(0, 3, 32'h1234);
    do_start(4'b0001, 1'b0, '0);
    begin
      int k;
      for (k = 0; k < 50 && cap_oe == '0; k++) @(negedge clk);
      if (cap_oe == '0) bound_expired("t5_read");
    end
    #1 rst = 1'b1;
    #1;
    chk("t5_oe_async", cap_oe, 0);
    chk("t5_valid_async", res_valid, 0);
    chk("t5_busy_async", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_dir(0, 3, 32'h55);
    b = log_q.size();
    do_start(4'b0001, 1'b0, '0);
    wait_results(b + 1, 100, "t5_restart");
    wait_idle(50, "t5_idle");
    if (log_q.size() > b) chk("t5_restart_data", log_q[b].data, 32'h55);

`ifdef PULSE_CAPTURE_SCHED_TIMEOUT_EN
    // ch1 answers, ch0 never does and is reported as a timeout.
    set_dir(0, -1, '0);
    set_dir(1, 5, 32'h77);
    b = log_q.size(); c0 = clr0_cnt;
    do_start(4'b0011, 1'b0, TW'(50));
    wait_results(b + 2, 300, "t6_results");
    wait_idle(50, "t6_idle");
    if (log_q.size() >= b + 2) begin
      chk("t6_first_ch", log_q[b].ch, 1);
      chk("t6_first_data", log_q[b].data, 32'h77);
      chk("t6_first_to", log_q[b].to, 0);
      chk("t6_to_ch", log_q[b + 1].ch, 0);
      chk("t6_to_data", log_q[b + 1].data, 0);
      chk("t6_to_flag", log_q[b + 1].to, 1);
    end
    chk("t6_no_clr0", clr0_cnt - c0, 0);
    set_dir(1, -1, '0);
`else
    c0 = clr0_cnt;
    chk("clr0_counted", clr0_cnt >= c0, 1);
`endif

    // Randomised rounds: one result per masked channel.
    rand_mode = 1'b1; ready_mode = 1;
    for (int r = 0; r < 25; r++) begin
      m = N'($urandom_range(1, 15));
      b = log_q.size();
      do_start(m, 1'b0, TW'($urandom_range(0, 40)));
      wait_idle(3000, "rand_idle");
      chk("rand_count", log_q.size() - b, $countones(m));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
